// File: rtl/avalon_pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : avalon_pwm_capture
// Purpose  : Avalon-MM slave measuring high time and period of an external
//            PWM input in clk cycles, exposed through read-only registers.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pwm_capture #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        pwm_in
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;

    localparam logic [1:0] c_addr_high   = 2'd0;
    localparam logic [1:0] c_addr_period = 2'd1;
    localparam logic [1:0] c_addr_status = 2'd2;
    localparam logic [1:0] c_addr_ctrl   = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_s3;
    logic                 r_en;
    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_shadow;
    logic [CNT_WIDTH-1:0] r_high_time;
    logic [CNT_WIDTH-1:0] r_period;
    logic                 r_valid;
    logic                 r_timeout;
    logic                 r_ovr;

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_period_rd;
    logic                 w_ctrl_wr;
    logic                 w_measuring;
    logic                 w_capture;
    logic                 w_tmo;
    logic [31:0]          w_rdata;
    logic                 w_unused_wdata;

    assign w_rise         = r_s2 & ~r_s3;
    assign w_fall         = ~r_s2 & r_s3;
    assign w_period_rd    = read && (address == c_addr_period);
    assign w_ctrl_wr      = write && (address == c_addr_ctrl);
    assign w_measuring    = (r_state == S_MEASURE) && r_en;
    assign w_capture      = w_measuring && w_rise;
    assign w_tmo          = w_measuring && !w_rise && (r_count == c_timeout);
    assign w_unused_wdata = ^writedata[31:1];

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_en <= writedata[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_shadow <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_count  <= '0;
                    r_shadow <= '0;
                    if (r_en) begin
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!r_en) begin
                        r_state  <= S_IDLE;
                        r_count  <= '0;
                        r_shadow <= '0;
                    end else if (w_rise) begin
                        r_state  <= S_MEASURE;
                        r_count  <= c_cnt_one;
                        r_shadow <= '0;
                    end
                end
                S_MEASURE: begin
                    if (!r_en) begin
                        r_state  <= S_IDLE;
                        r_count  <= '0;
                        r_shadow <= '0;
                    end else if (w_rise) begin
                        r_count <= c_cnt_one;
                    end else if (r_count == c_timeout) begin
                        r_state <= S_ARM;
                        r_count <= '0;
                    end else begin
                        if (r_count != c_cnt_max) begin
                            r_count <= r_count + c_cnt_one;
                        end
                        if (w_fall) begin
                            r_shadow <= r_count;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_count  <= '0;
                    r_shadow <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_high_time <= '0;
            r_period    <= '0;
        end else if (w_capture) begin
            r_high_time <= r_shadow;
            r_period    <= r_count;
        end else if (w_tmo) begin
            r_high_time <= '0;
            r_period    <= '0;
        end
    end

    // A capture coinciding with a PERIOD read: set wins for VALID, and the
    // result being read is not counted as overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_valid <= 1'b1;
            end else if (w_period_rd) begin
                r_valid <= 1'b0;
            end

            if (w_capture && r_valid && !w_period_rd) begin
                r_ovr <= 1'b1;
            end else if (w_period_rd) begin
                r_ovr <= 1'b0;
            end

            if (w_capture) begin
                r_timeout <= 1'b0;
            end else if (w_tmo) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (address)
            c_addr_high:   w_rdata = 32'(r_high_time);
            c_addr_period: w_rdata = 32'(r_period);
            c_addr_status: w_rdata = {28'd0, r_ovr, r_s2, r_timeout, r_valid};
            c_addr_ctrl:   w_rdata = {31'd0, r_en};
            default:       w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 32'd0;
        end else if (read) begin
            readdata <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_avalon_pwm_capture
// Purpose  : Directed self-checking bench for avalon_pwm_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_pwm_capture;

    localparam logic [1:0] c_high   = 2'd0;
    localparam logic [1:0] c_period = 2'd1;
    localparam logic [1:0] c_status = 2'd2;
    localparam logic [1:0] c_ctrl   = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        pwm_in;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cur_e   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    int          pwm_hi   = 3;
    int          pwm_lo   = 5;
    logic        pwm_on   = 1'b0;
    logic        pwm_hold = 1'b0;

    always #5 clk = ~clk;

    avalon_pwm_capture #(
        .CNT_WIDTH(32),
        .TIMEOUT  (100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .pwm_in   (pwm_in)
    );

    // PWM source: pin changes 1 time unit after each rising clock edge
    initial begin : g_pwm_gen
        int ph;
        ph     = 0;
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pwm_on) begin
                pwm_in = (ph < pwm_hi);
                ph     = (ph + 1 >= pwm_hi + pwm_lo) ? 0 : ph + 1;
            end else begin
                pwm_in = pwm_hold;
                ph     = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Read sampled by the DUT on edge k (counted from the last window origin)
    task automatic read_at(input int k, input logic [1:0] a, input logic [31:0] exp, input string tag);
        for (int i = cur_e + 2; i < k; i++) @(posedge clk);
        @(posedge clk);
        #1;
        address = a;
        read    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        read = 1'b0;
        check(tag_q.pop_front(), readdata, exp_q.pop_front());
        cur_e = k;
    endtask

    task automatic write_at(input int k, input logic [1:0] a, input logic [31:0] d);
        for (int i = cur_e + 2; i < k; i++) @(posedge clk);
        @(posedge clk);
        #1;
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        cur_e = k;
    endtask

    // Window origin E0: the rising clock edge just before the pin fell
    task automatic wait_fall();
        logic prev;
        bit   found;
        found = 1'b0;
        #1;
        prev = pwm_in;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #2;
            if (prev && !pwm_in) found = 1'b1;
            prev = pwm_in;
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $error("FAIL wait_fall: observed no falling edge, expected one within 400 cycles");
        end
        cur_e = 0;
    endtask

    initial begin : g_watchdog
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_readdata", readdata, 32'd0);
        cur_e = 0;
        read_at(2, c_high,   32'd0, "rst_high");
        read_at(4, c_period, 32'd0, "rst_period");
        read_at(6, c_status, 32'd0, "rst_status");
        read_at(8, c_ctrl,   32'd0, "rst_ctrl");
        write_at(10, c_high, 32'h1234);
        write_at(12, c_ctrl, 32'hFFFF_FFFF);
        read_at(14, c_ctrl, 32'd1, "ctrl_en_readback");
        read_at(16, c_high, 32'd0, "high_write_ignored");

        // 3-high / 5-low stream
        pwm_hi = 3;
        pwm_lo = 5;
        pwm_on = 1'b1;
        wait_fall();
        read_at(4, c_status, 32'h0, "one_rise_no_valid");
        wait_fall();
        read_at(4, c_status, 32'h1, "first_valid");
        read_at(6, c_high,   32'd3, "high_3_5");
        wait_fall();
        read_at(4, c_status, 32'h9, "ovr_set");
        read_at(6, c_period, 32'd8, "period_3_5");
        wait_fall();
        read_at(4, c_period, 32'd8, "period_again");
        read_at(6, c_status, 32'h0, "period_read_clears");

        // Stop after this rise: timeout 100 cycles after the rise at E0
        wait_fall();
        pwm_on   = 1'b0;
        pwm_hold = 1'b0;
        read_at(100, c_status, 32'h1, "before_timeout");
        read_at(102, c_status, 32'h3, "timeout_set");
        read_at(104, c_high,   32'd0, "timeout_high_zero");
        read_at(106, c_period, 32'd0, "timeout_period_zero");
        read_at(108, c_status, 32'h2, "timeout_valid_cleared");

        // 10-high / 40-low stream; captures land on edge 43 of each window
        pwm_hi = 10;
        pwm_lo = 40;
        pwm_on = 1'b1;
        wait_fall();
        read_at(4,  c_status, 32'h2,  "rearm_no_valid");
        read_at(43, c_period, 32'd0,  "coincident_old_period");
        read_at(45, c_status, 32'h5,  "coincident_valid_set");
        wait_fall();
        read_at(4,  c_high,   32'd10, "high_10_40");
        read_at(43, c_period, 32'd50, "period_10_40");
        read_at(45, c_status, 32'h5,  "coincident_no_ovr");

        // Disable mid-period; results retained, no new capture
        wait_fall();
        write_at(4, c_ctrl, 32'd0);
        read_at(8,  c_high,   32'd10, "disable_high_kept");
        read_at(10, c_period, 32'd50, "disable_period_kept");
        read_at(12, c_status, 32'h0,  "disable_status");
        read_at(50, c_status, 32'h4,  "disabled_no_capture");
        write_at(55, c_ctrl, 32'd1);
        wait_fall();
        read_at(4,  c_status, 32'h0,  "reenable_one_rise");
        read_at(45, c_status, 32'h5,  "reenable_two_rises");

        // Asynchronous reset in the middle of a measurement
        wait_fall();
        read_at(4, c_period, 32'd50, "pre_reset_period");
        read_at(6, c_high,   32'd10, "pre_reset_high");
        for (int i = cur_e; i < 10; i++) @(posedge clk);
        #1;
        check("readdata_hold", readdata, 32'd10);
        for (int i = 10; i < 20; i++) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("reset_async", readdata, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        cur_e = 22;
        read_at(24, c_high,   32'd0, "post_rst_high");
        read_at(26, c_period, 32'd0, "post_rst_period");
        read_at(28, c_status, 32'd0, "post_rst_status");
        read_at(30, c_ctrl,   32'd0, "post_rst_ctrl");
        write_at(32, c_ctrl, 32'd1);
        wait_fall();
        read_at(4, c_status, 32'h0,  "post_rst_one_rise");
        wait_fall();
        read_at(4, c_status, 32'h1,  "post_rst_valid");
        read_at(6, c_high,   32'd10, "post_rst_high_meas");
        read_at(8, c_period, 32'd50, "post_rst_period_meas");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
